dram_burst_splitter: RTL and testbench

- Sits between the AXI interconnect slave port and the DRAM AXI wrapper.
- The DRAM wrapper serves single-beat transactions only: RLAST is always 1, and it takes one W beat per AW.
- This block accepts AXI bursts (len 0..15) upstream and issues them downstream as a sequence of single-beat transactions.
- It reassembles one R burst or one B response for the master.
- One transaction is in flight at a time; reads have priority.

---
 rtl/dram_burst_splitter.sv | 254 +++++++++++++++++++++++++
 tb/tb_dram_burst_splitter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_splitter.sv
// Splits upstream AXI bursts (len 0..15) into single-beat DRAM transactions and
// reassembles one R burst or one B response; one burst in flight, reads first.
module dram_burst_splitter #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     S_ARID,
  input  logic [ADDR_W-1:0]   S_ARADDR,
  input  logic [3:0]          S_ARLEN,
  input  logic [2:0]          S_ARSIZE,
  input  logic [1:0]          S_ARBURST,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [ID_W-1:0]     S_RID,
  output logic [DATA_W-1:0]   S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RLAST,
  output logic                S_RVALID,
  input  logic                S_RREADY,
  input  logic [ID_W-1:0]     S_AWID,
  input  logic [ADDR_W-1:0]   S_AWADDR,
  input  logic [3:0]          S_AWLEN,
  input  logic [2:0]          S_AWSIZE,
  input  logic [1:0]          S_AWBURST,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  input  logic [DATA_W-1:0]   S_WDATA,
  input  logic [DATA_W/8-1:0] S_WSTRB,
  input  logic                S_WLAST,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [ID_W-1:0]     S_BID,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  output logic [ID_W-1:0]     M_ARID,
  output logic [ADDR_W-1:0]   M_ARADDR,
  output logic [3:0]          M_ARLEN,
  output logic [2:0]          M_ARSIZE,
  output logic [1:0]          M_ARBURST,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  input  logic [ID_W-1:0]     M_RID,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic [1:0]          M_RRESP,
  input  logic                M_RLAST,
  input  logic                M_RVALID,
  output logic                M_RREADY,
  output logic [ID_W-1:0]     M_AWID,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic [3:0]          M_AWLEN,
  output logic [2:0]          M_AWSIZE,
  output logic [1:0]          M_AWBURST,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WLAST,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic [ID_W-1:0]     M_BID,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_AR   = 3'd1,
    R_R    = 3'd2,
    W_AW   = 3'd3,
    W_W    = 3'd4,
    W_B    = 3'd5,
    W_RESP = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;
  logic [1:0]          resp_acc_q, resp_acc_d;
  logic                live_q;
  logic                last_s;
  logic                unused_s;

  // FIXED holds the address; INCR and WRAP both step by one beat.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + STRIDE;
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

  assign last_s   = (beat_cnt_q == len_q);
  assign unused_s = ^{S_ARSIZE, S_AWSIZE, M_RID, M_RLAST, M_BID};

  assign M_ARID    = id_q;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = 4'd0;
  assign M_ARSIZE  = 3'b010;
  assign M_ARBURST = 2'b01;
  assign M_AWID    = id_q;
  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = 4'd0;
  assign M_AWSIZE  = 3'b010;
  assign M_AWBURST = 2'b01;
  assign S_RID     = id_q;
  assign S_RDATA   = M_RDATA;
  assign S_RRESP   = M_RRESP;
  assign S_RLAST   = last_s;
  assign M_WDATA   = S_WDATA;
  assign M_WSTRB   = S_WSTRB;
  assign M_WLAST   = 1'b1;
  assign S_BID     = id_q;
  assign S_BRESP   = err_q ? 2'b10 : resp_acc_q;

  // State and latched burst context; live_q keeps every ready low while in reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= 4'd0;
      burst_q    <= 2'b00;
      beat_cnt_q <= 4'd0;
      err_q      <= 1'b0;
      resp_acc_q <= 2'b00;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      resp_acc_q <= resp_acc_d;
      live_q     <= 1'b1;
    end
  end

  // Next-state logic and handshake gating.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    resp_acc_d = resp_acc_q;
    S_ARREADY  = 1'b0;
    S_AWREADY  = 1'b0;
    S_RVALID   = 1'b0;
    M_RREADY   = 1'b0;
    M_ARVALID  = 1'b0;
    M_AWVALID  = 1'b0;
    M_WVALID   = 1'b0;
    S_WREADY   = 1'b0;
    M_BREADY   = 1'b0;
    S_BVALID   = 1'b0;
    case (state_q)
      IDLE: begin
        S_ARREADY = live_q;
        S_AWREADY = live_q & ~S_ARVALID;
        if (live_q && S_ARVALID) begin
          id_d       = S_ARID;
          addr_d     = S_ARADDR;
          len_d      = S_ARLEN;
          burst_d    = S_ARBURST;
          beat_cnt_d = 4'd0;
          state_d    = R_AR;
        end else if (live_q && S_AWVALID) begin
          id_d       = S_AWID;
          addr_d     = S_AWADDR;
          len_d      = S_AWLEN;
          burst_d    = S_AWBURST;
          beat_cnt_d = 4'd0;
          err_d      = 1'b0;
          resp_acc_d = 2'b00;
          state_d    = W_AW;
        end else begin
          state_d = IDLE;
        end
      end
      R_AR: begin
        M_ARVALID = 1'b1;
        state_d   = M_ARREADY ? R_R : R_AR;
      end
      R_R: begin
        S_RVALID = M_RVALID;
        M_RREADY = S_RREADY;
        if (M_RVALID && S_RREADY) begin
          if (last_s) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            addr_d     = next_addr(addr_q, burst_q);
            state_d    = R_AR;
          end
        end else begin
          state_d = R_R;
        end
      end
      W_AW: begin
        M_AWVALID = 1'b1;
        state_d   = M_AWREADY ? W_W : W_AW;
      end
      W_W: begin
        M_WVALID = S_WVALID;
        S_WREADY = M_WREADY;
        if (S_WVALID && M_WREADY) begin
          err_d   = err_q | (S_WLAST != last_s);
          state_d = W_B;
        end else begin
          state_d = W_W;
        end
      end
      W_B: begin
        M_BREADY = 1'b1;
        if (M_BVALID) begin
          resp_acc_d = resp_max(resp_acc_q, M_BRESP);
          if (last_s) begin
            state_d = W_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            addr_d     = next_addr(addr_q, burst_q);
            state_d    = W_AW;
          end
        end else begin
          state_d = W_B;
        end
      end
      W_RESP: begin
        S_BVALID = 1'b1;
        state_d  = S_BREADY ? IDLE : W_RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dram_burst_splitter.sv
// Directed bench for dram_burst_splitter: a single-beat DRAM responder plus
// handshake logs feed hand-computed expectations checked with immediate asserts.
module tb_dram_burst_splitter;

  logic ACLK, ARESETn;
  logic [7:0] S_ARID, S_RID, S_AWID, S_BID, M_ARID, M_RID, M_AWID, M_BID;
  logic [31:0] S_ARADDR, S_AWADDR, M_ARADDR, M_AWADDR;
  logic [3:0] S_ARLEN, S_AWLEN, M_ARLEN, M_AWLEN;
  logic [2:0] S_ARSIZE, S_AWSIZE, M_ARSIZE, M_AWSIZE;
  logic [1:0] S_ARBURST, S_AWBURST, M_ARBURST, M_AWBURST;
  logic S_ARVALID, S_ARREADY, S_AWVALID, S_AWREADY, M_ARVALID, M_ARREADY, M_AWVALID, M_AWREADY;
  logic [31:0] S_RDATA, M_RDATA, S_WDATA, M_WDATA;
  logic [1:0] S_RRESP, M_RRESP, S_BRESP, M_BRESP;
  logic S_RLAST, S_RVALID, S_RREADY, M_RLAST, M_RVALID, M_RREADY;
  logic [3:0] S_WSTRB, M_WSTRB;
  logic S_WLAST, S_WVALID, S_WREADY, M_WLAST, M_WVALID, M_WREADY;
  logic S_BVALID, S_BREADY, M_BVALID, M_BREADY;

  dram_burst_splitter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [1:0] bresp_cfg;
  logic [7:0] awid_r;

  // Read data is a fixed function of the address so delivered beats can be traced.
  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Single-beat DRAM wrapper model: one R per AR, one B per W, idle BRESP is 2'b11.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      M_RVALID <= 1'b0; M_RDATA <= 32'd0; M_RID <= 8'd0; M_RRESP <= 2'b00; M_RLAST <= 1'b0;
      M_BVALID <= 1'b0; M_BRESP <= 2'b11; M_BID <= 8'd0; awid_r <= 8'd0;
    end else begin
      if (M_ARVALID && M_ARREADY) begin
        M_RVALID <= 1'b1; M_RDATA <= rd_pat(M_ARADDR); M_RID <= M_ARID;
        M_RRESP <= 2'b00; M_RLAST <= 1'b1;
      end else if (M_RVALID && M_RREADY) begin
        M_RVALID <= 1'b0;
      end
      if (M_AWVALID && M_AWREADY) awid_r <= M_AWID;
      if (M_WVALID && M_WREADY) begin
        M_BVALID <= 1'b1; M_BRESP <= bresp_cfg; M_BID <= awid_r;
      end else if (M_BVALID && M_BREADY) begin
        M_BVALID <= 1'b0; M_BRESP <= 2'b11;
      end
    end
  end

  logic [31:0] ar_addr_l [64]; logic [3:0] ar_len_l [64]; logic [7:0] ar_id_l [64];
  logic [2:0]  ar_size_l [64]; logic [1:0] ar_burst_l [64];
  logic [31:0] aw_addr_l [64]; logic [3:0] aw_len_l [64];
  logic [31:0] w_data_l [64];  logic [3:0] w_strb_l [64]; logic w_last_l [64];
  logic [31:0] r_data_l [64];  logic r_last_l [64]; logic [7:0] r_id_l [64];
  logic [7:0]  b_id_l [64];    logic [1:0] b_resp_l [64]; int b_mb_l [64];
  int ar_n = 0, aw_n = 0, w_n = 0, r_n = 0, b_n = 0, mb_n = 0;

  // Handshake logs on both sides of the DUT.
  always @(posedge ACLK) begin
    if (M_ARVALID && M_ARREADY) begin
      ar_addr_l[ar_n] <= M_ARADDR; ar_len_l[ar_n] <= M_ARLEN; ar_id_l[ar_n] <= M_ARID;
      ar_size_l[ar_n] <= M_ARSIZE; ar_burst_l[ar_n] <= M_ARBURST; ar_n <= ar_n + 1;
    end
    if (M_AWVALID && M_AWREADY) begin
      aw_addr_l[aw_n] <= M_AWADDR; aw_len_l[aw_n] <= M_AWLEN; aw_n <= aw_n + 1;
    end
    if (M_WVALID && M_WREADY) begin
      w_data_l[w_n] <= M_WDATA; w_strb_l[w_n] <= M_WSTRB; w_last_l[w_n] <= M_WLAST; w_n <= w_n + 1;
    end
    if (S_RVALID && S_RREADY) begin
      r_data_l[r_n] <= S_RDATA; r_last_l[r_n] <= S_RLAST; r_id_l[r_n] <= S_RID; r_n <= r_n + 1;
    end
    if (M_BVALID && M_BREADY) mb_n <= mb_n + 1;
    if (S_BVALID && S_BREADY) begin
      b_id_l[b_n] <= S_BID; b_resp_l[b_n] <= S_BRESP; b_mb_l[b_n] <= mb_n; b_n <= b_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    logic ok;
    S_ARID = id; S_ARADDR = a; S_ARLEN = len; S_ARSIZE = 3'b010; S_ARBURST = burst; S_ARVALID = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (S_ARREADY) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    chk("ar_handshake", 32'(ok), 32'd1);
    @(negedge ACLK);
    S_ARVALID = 1'b0;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    logic ok;
    S_AWID = id; S_AWADDR = a; S_AWLEN = len; S_AWSIZE = 3'b010; S_AWBURST = burst; S_AWVALID = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (S_AWREADY) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    chk("aw_handshake", 32'(ok), 32'd1);
    @(negedge ACLK);
    S_AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
    logic ok;
    S_WDATA = d; S_WSTRB = strb; S_WLAST = last; S_WVALID = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (S_WREADY) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    chk("w_handshake", 32'(ok), 32'd1);
    @(negedge ACLK);
    S_WVALID = 1'b0;
  endtask

  task automatic wait_r(input int target);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (r_n >= target) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    chk("r_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_b(input int target);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (b_n >= target) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    chk("b_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    int ab, awb, wb, rb, bb, mbb;
    logic early, bad;
    logic [31:0] held;
    ARESETn = 1'b0;
    S_ARID = 8'd0; S_ARADDR = 32'd0; S_ARLEN = 4'd0; S_ARSIZE = 3'd0; S_ARBURST = 2'd0; S_ARVALID = 1'b0;
    S_AWID = 8'd0; S_AWADDR = 32'd0; S_AWLEN = 4'd0; S_AWSIZE = 3'd0; S_AWBURST = 2'd0; S_AWVALID = 1'b0;
    S_WDATA = 32'd0; S_WSTRB = 4'd0; S_WLAST = 1'b0; S_WVALID = 1'b0;
    S_RREADY = 1'b1; S_BREADY = 1'b1;
    M_ARREADY = 1'b1; M_AWREADY = 1'b1; M_WREADY = 1'b1; bresp_cfg = 2'b00;

    cyc(2); #1;
    chk("rst_arready", 32'(S_ARREADY), 32'd0);
    chk("rst_awready", 32'(S_AWREADY), 32'd0);
    chk("rst_m_arvalid", 32'(M_ARVALID), 32'd0);
    chk("rst_s_bvalid", 32'(S_BVALID), 32'd0);
    @(negedge ACLK); ARESETn = 1'b1;
    cyc(2);
    chk("idle_arready", 32'(S_ARREADY), 32'd1);
    chk("idle_awready", 32'(S_AWREADY), 32'd1);

    // INCR read, 4 beats
    ab = ar_n; rb = r_n;
    ar_send(8'h15, 32'h0000_2010, 4'd3, 2'b01);
    wait_r(rb + 4);
    cyc(2);
    chk("t1_ar_count", 32'(ar_n - ab), 32'd4);
    chk("t1_r_count", 32'(r_n - rb), 32'd4);
    chk("t1_ar_id", 32'(ar_id_l[ab]), 32'h15);
    chk("t1_ar_size", 32'(ar_size_l[ab]), 32'd2);
    chk("t1_ar_burst", 32'(ar_burst_l[ab]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_ar_addr", ar_addr_l[ab + i], 32'h0000_2010 + 32'(4 * i));
      chk("t1_ar_len", 32'(ar_len_l[ab + i]), 32'd0);
      chk("t1_r_data", r_data_l[rb + i], rd_pat(32'h0000_2010 + 32'(4 * i)));
      chk("t1_r_last", 32'(r_last_l[rb + i]), (i == 3) ? 32'd1 : 32'd0);
      chk("t1_r_id", 32'(r_id_l[rb + i]), 32'h15);
    end
    chk("t1_idle", 32'(S_ARREADY), 32'd1);

    // INCR write, 2 beats; one B only after the second downstream B
    awb = aw_n; wb = w_n; bb = b_n; mbb = mb_n;
    aw_send(8'h3C, 32'h0000_0100, 4'd1, 2'b01);
    w_beat(32'hAAAA_5555, 4'hF, 1'b0);
    w_beat(32'h1234_5678, 4'hF, 1'b1);
    wait_b(bb + 1);
    cyc(3);
    chk("t2_aw_addr0", aw_addr_l[awb], 32'h0000_0100);
    chk("t2_aw_addr1", aw_addr_l[awb + 1], 32'h0000_0104);
    chk("t2_aw_len", 32'(aw_len_l[awb + 1]), 32'd0);
    chk("t2_w_data0", w_data_l[wb], 32'hAAAA_5555);
    chk("t2_w_data1", w_data_l[wb + 1], 32'h1234_5678);
    chk("t2_w_strb", 32'(w_strb_l[wb]), 32'hF);
    chk("t2_w_last0", 32'(w_last_l[wb]), 32'd1);
    chk("t2_b_count", 32'(b_n - bb), 32'd1);
    chk("t2_b_id", 32'(b_id_l[bb]), 32'h3C);
    chk("t2_b_resp", 32'(b_resp_l[bb]), 32'd0);
    chk("t2_b_after_mb", 32'(b_mb_l[bb] - mbb), 32'd2);

    // Simultaneous AR/AW: read wins, AW held off until the last R
    rb = r_n; awb = aw_n; bb = b_n;
    S_ARID = 8'h21; S_ARADDR = 32'h0000_0500; S_ARLEN = 4'd1; S_ARSIZE = 3'b010; S_ARBURST = 2'b01;
    S_AWID = 8'h22; S_AWADDR = 32'h0000_0600; S_AWLEN = 4'd0; S_AWSIZE = 3'b010; S_AWBURST = 2'b01;
    S_ARVALID = 1'b1; S_AWVALID = 1'b1;
    #1;
    chk("t3_arready", 32'(S_ARREADY), 32'd1);
    chk("t3_awready_blocked", 32'(S_AWREADY), 32'd0);
    @(negedge ACLK); S_ARVALID = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (r_n >= rb + 2) break;
      if (S_AWREADY) early = 1'b1;
      @(negedge ACLK);
    end
    chk("t3_aw_held_during_read", 32'(early), 32'd0);
    chk("t3_r_last", 32'(r_last_l[rb + 1]), 32'd1);
    chk("t3_r_data1", r_data_l[rb + 1], rd_pat(32'h0000_0504));
    aw_send(8'h22, 32'h0000_0600, 4'd0, 2'b01);
    w_beat(32'hCAFE_F00D, 4'h3, 1'b1);
    wait_b(bb + 1);
    chk("t3_aw_addr", aw_addr_l[awb], 32'h0000_0600);
    chk("t3_b_id", 32'(b_id_l[bb]), 32'h22);

    // Downstream EXOKAY propagates on a single-beat write
    bb = b_n; bresp_cfg = 2'b01;
    aw_send(8'h40, 32'h0000_0800, 4'd0, 2'b01);
    w_beat(32'h0000_0001, 4'h1, 1'b1);
    wait_b(bb + 1);
    chk("t4_b_resp_exokay", 32'(b_resp_l[bb]), 32'd1);
    bresp_cfg = 2'b00;

    // Early WLAST on beat 1 of 3 gives SLVERR
    bb = b_n;
    aw_send(8'h51, 32'h0000_0700, 4'd2, 2'b01);
    w_beat(32'h1111_1111, 4'hF, 1'b1);
    w_beat(32'h2222_2222, 4'hF, 1'b0);
    w_beat(32'h3333_3333, 4'hF, 1'b1);
    wait_b(bb + 1);
    chk("t5_b_resp_err", 32'(b_resp_l[bb]), 32'd2);

    // WRAP behaves as INCR and the address rolls over 2^32; err cleared
    awb = aw_n; bb = b_n;
    aw_send(8'h66, 32'hFFFF_FFFC, 4'd1, 2'b10);
    w_beat(32'h4444_4444, 4'hF, 1'b0);
    w_beat(32'h5555_5555, 4'hF, 1'b1);
    wait_b(bb + 1);
    chk("t6_aw_addr0", aw_addr_l[awb], 32'hFFFF_FFFC);
    chk("t6_aw_addr1_wrap", aw_addr_l[awb + 1], 32'h0000_0000);
    chk("t6_b_resp_ok", 32'(b_resp_l[bb]), 32'd0);

    // FIXED read stays on one address
    ab = ar_n; rb = r_n;
    ar_send(8'h30, 32'h0000_3000, 4'd2, 2'b00);
    wait_r(rb + 3);
    for (int i = 0; i < 3; i++) begin
      chk("t7_ar_addr_fixed", ar_addr_l[ab + i], 32'h0000_3000);
      chk("t7_r_last", 32'(r_last_l[rb + i]), (i == 2) ? 32'd1 : 32'd0);
    end

    // Upstream back-pressure on beat 2 for 5 cycles
    rb = r_n;
    ar_send(8'h31, 32'h0000_4000, 4'd2, 2'b01);
    wait_r(rb + 1);
    S_RREADY = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (S_RVALID) break;
      @(negedge ACLK);
    end
    held = S_RDATA;
    bad = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (M_RREADY !== 1'b0 || S_RDATA !== held || S_RVALID !== 1'b1) bad = 1'b1;
      @(negedge ACLK); #1;
    end
    chk("t8_stall_stable", 32'(bad), 32'd0);
    chk("t8_stall_data", held, rd_pat(32'h0000_4004));
    chk("t8_no_beat_during_stall", 32'(r_n - rb), 32'd1);
    S_RREADY = 1'b1;
    wait_r(rb + 3);
    cyc(3);
    chk("t8_r_count", 32'(r_n - rb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t8_r_data", r_data_l[rb + i], rd_pat(32'h0000_4000 + 32'(4 * i)));
      chk("t8_r_last", 32'(r_last_l[rb + i]), (i == 2) ? 32'd1 : 32'd0);
    end

    // Reset mid-burst aborts; a fresh read afterwards completes
    rb = r_n;
    ar_send(8'h70, 32'h0000_8000, 4'd3, 2'b01);
    wait_r(rb + 1);
    ARESETn = 1'b0;
    #1;
    chk("t9_rst_m_arvalid", 32'(M_ARVALID), 32'd0);
    chk("t9_rst_s_rvalid", 32'(S_RVALID), 32'd0);
    chk("t9_rst_m_rready", 32'(M_RREADY), 32'd0);
    chk("t9_rst_arready", 32'(S_ARREADY), 32'd0);
    chk("t9_rst_m_awvalid", 32'(M_AWVALID), 32'd0);
    cyc(2);
    ARESETn = 1'b1;
    cyc(2);
    chk("t9_idle_after_rst", 32'(S_ARREADY), 32'd1);
    chk("t9_no_arvalid_after_rst", 32'(M_ARVALID), 32'd0);
    ab = ar_n; rb = r_n;
    ar_send(8'h44, 32'h0000_9000, 4'd0, 2'b01);
    wait_r(rb + 1);
    cyc(3);
    chk("t9_ar_count", 32'(ar_n - ab), 32'd1);
    chk("t9_r_count", 32'(r_n - rb), 32'd1);
    chk("t9_r_last", 32'(r_last_l[rb]), 32'd1);
    chk("t9_r_id", 32'(r_id_l[rb]), 32'h44);
    chk("t9_r_data", r_data_l[rb], rd_pat(32'h0000_9000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
